// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, stall (freeze) and flush.
// Define PIPE_SKID_EN to add a skid entry so that in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The encoding doubles as the live-entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = main_q;
  assign out_fire  = out_valid & out_ready & ~freeze;
  assign in_fire   = in_valid & in_ready;

`ifdef PIPE_SKID_EN

  logic [DATA_W-1:0] skid_q;
  logic              ready_q;

  assign in_ready = ready_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: payload registers are reset too, because a reset or flushed stage
    // must present CLEAR_VAL (a NOP) rather than stale data.
    if (!rst) begin
      state   <= EMPTY;
      main_q  <= CLEAR_VAL;
      skid_q  <= CLEAR_VAL;
      ready_q <= 1'b1;
    end else if (flush) begin
      state   <= EMPTY;
      main_q  <= CLEAR_VAL;
      skid_q  <= CLEAR_VAL;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= FULL;
          end
        end
        FULL: begin
          if (out_fire && in_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end else if (in_fire) begin
            // Downstream stalled: park the extra payload and stop accepting.
            skid_q  <= in_data;
            state   <= SKID;
            ready_q <= 1'b0;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state   <= FULL;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`else

  // Accept when empty or when the held payload leaves this same cycle.
  assign in_ready = ~out_valid | out_fire;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: payload registers are reset too, because a reset or flushed stage
    // must present CLEAR_VAL (a NOP) rather than stale data.
    if (!rst) begin
      state  <= EMPTY;
      main_q <= CLEAR_VAL;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= CLEAR_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= FULL;
          end
        end
        FULL: begin
          if (out_fire && in_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int W = 64;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         freeze = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic [W-1:0] q[$];
  logic [W-1:0] shown = '0;
  int           n_tests = 0;
  int           n_fail = 0;

  pipe_stage_reg #(.DATA_W(W), .CLEAR_VAL('0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic bit m_in_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || (out_ready && !freeze);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check("out_valid", W'(out_valid), W'(q.size() > 0));
    check("out_data", out_data, (q.size() > 0) ? q[0] : shown);
    check("occupancy", W'(occupancy), W'(q.size()));
    check("in_ready", W'(in_ready), W'(m_in_ready()));
  endtask

  // One clock: drive inputs, check before the edge, advance the model at the edge.
  task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy,
                       input bit frz, input bit fl);
    bit ir;
    bit of;
    in_valid = iv; in_data = d; out_ready = ordy; freeze = frz; flush = fl;
    @(negedge clk);
    check_model();
    ir = m_in_ready();
    of = (q.size() > 0) && ordy && !frz;
    @(posedge clk);
    if (fl) begin
      q.delete();
      shown = '0;
    end else begin
      if (of) shown = q.pop_front();
      if (iv && ir) q.push_back(d);
    end
    #1;
  endtask

  initial begin
    // Reset held with a live upstream payload.
    in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_occupancy", W'(occupancy), '0);
    rst = 1'b1;
    @(posedge clk);
    q.push_back(64'hDEAD);
    #1;
    check("rst_release_data", out_data, 64'hDEAD);
    check("rst_release_valid", W'(out_valid), W'(1));

    // Streaming 1..4 back to back.
    cycle(0, '0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1, W'(k), 1, 0, 0);
      check("stream_data", out_data, W'(k));
    end
    cycle(0, '0, 1, 0, 0);
    check("stream_drain", W'(out_valid), '0);

    // Stall with skid absorption.
    cycle(1, W'(5), 0, 0, 0);
    cycle(1, W'(6), 0, 0, 0);
    cycle(1, W'(7), 0, 0, 0);
`ifdef PIPE_SKID_EN
    check("skid_occupancy", W'(occupancy), W'(2));
    check("skid_in_ready", W'(in_ready), '0);
    cycle(1, W'(7), 1, 0, 0);
    check("skid_out6", out_data, W'(6));
    cycle(1, W'(7), 1, 0, 0);
    check("skid_out7", out_data, W'(7));
`else
    check("noskid_occupancy", W'(occupancy), W'(1));
`endif
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0);

    // Freeze holds the payload even with out_ready high.
    cycle(1, W'(9), 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, '0, 1, 1, 0);
      check("freeze_data", out_data, W'(9));
      check("freeze_valid", W'(out_valid), W'(1));
    end
    cycle(0, '0, 1, 0, 0);
    check("freeze_release", W'(out_valid), '0);
    check("freeze_keep_data", out_data, W'(9));

    // Flush with a concurrent push, then flush together with freeze.
    for (int f = 0; f < 2; f++) begin
      cycle(1, W'(10), 0, 0, 0);
      cycle(1, W'(11), 0, 0, 0);
      cycle(1, W'(8), 1, f[0], 1);
      check("flush_valid", W'(out_valid), '0);
      check("flush_occupancy", W'(occupancy), '0);
      check("flush_data", out_data, '0);
      cycle(0, '0, 1, 0, 0);
      check("flush_no8", out_data, '0);
    end

    // Asynchronous reset between edges.
    cycle(1, W'(12), 0, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", W'(out_valid), '0);
    check("async_rst_occ", W'(occupancy), '0);
    check("async_rst_data", out_data, '0);
    q.delete();
    shown = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
